// File: rtl/selftest_engine.sv
// Built-in self-test engine: per-channel LFSR pattern through a delay line, checked against a regenerated stream.
// Optional macro SELFTEST_FINISH_EN reports the result and ends simulation on entry to DONE.

module selftest_lane #(
  parameter int unsigned       WIDTH   = 16,
  parameter int unsigned       LATENCY = 2,
  parameter logic [WIDTH-1:0]  SEED_W  = '1,
  parameter logic [WIDTH-1:0]  POLY_W  = '0
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic launch,
  input  logic inject,
  output logic mism,
  output logic out_vld,
  output logic pend
);
  logic [LATENCY-1:0][WIDTH-1:0] dly;
  logic [LATENCY-1:0]            vld;
  logic [WIDTH-1:0]              gen, chk;

  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] x);
    return x[0] ? ((x >> 1) ^ POLY_W) : (x >> 1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dly <= '0;
      vld <= '0;
      gen <= '0;
      chk <= '0;
    end else if (load) begin
      vld <= '0;
      gen <= SEED_W;
      chk <= SEED_W;
    end else begin
      vld[0] <= launch;
      dly[0] <= gen ^ WIDTH'(inject);
      for (int i = 1; i < LATENCY; i++) begin
        dly[i] <= dly[i-1];
        vld[i] <= vld[i-1];
      end
      if (launch) gen <= lfsr_next(gen);
      if (vld[LATENCY-1]) chk <= lfsr_next(chk);
    end
  end

  assign out_vld = vld[LATENCY-1];
  assign mism    = vld[LATENCY-1] && (dly[LATENCY-1] != chk);

  // Words still in flight ahead of the checked stage; clear means the checked word is the last one.
  always_comb begin
    pend = 1'b0;
    for (int i = 0; i < LATENCY - 1; i++) pend = pend | vld[i];
  end
endmodule

module selftest_engine #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned NUM_CYCLES = 64,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned SEED       = 16'hACE1,
  parameter int unsigned POLY       = 16'hB400
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CHANNELS-1:0] inject_err,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [15:0]         err_count,
  output logic [CHANNELS-1:0] err_chan,
  output logic [15:0]         cycle_count
);
  localparam int unsigned CW = $clog2(NUM_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state;

  logic [CW-1:0]       launch_cnt;
  logic                load, launch, last_chk;
  logic [CHANNELS-1:0] mism, out_vld, pend;
  logic [31:0]         err_sum;
  logic [15:0]         err_next;

  assign load   = start && (state == IDLE || state == DONE);
  assign launch = (state == RUN);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    selftest_lane #(
      .WIDTH  (WIDTH),
      .LATENCY(LATENCY),
      .SEED_W (WIDTH'(SEED) ^ WIDTH'(c)),
      .POLY_W (WIDTH'(POLY))
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .load   (load),
      .launch (launch),
      .inject (inject_err[c]),
      .mism   (mism[c]),
      .out_vld(out_vld[c]),
      .pend   (pend[c])
    );
  end

  // Every lane has identical timing, so the drain end is the same on all of them.
  assign last_chk = (|out_vld) && !(|pend);

  always_comb begin
    err_sum = {16'd0, err_count};
    for (int c = 0; c < CHANNELS; c++) err_sum = err_sum + 32'(mism[c]);
    err_next = (err_sum > 32'h0000_FFFF) ? 16'hFFFF : err_sum[15:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_count   <= '0;
      err_chan    <= '0;
      cycle_count <= '0;
      launch_cnt  <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          state       <= RUN;
          busy        <= 1'b1;
          done        <= 1'b0;
          pass        <= 1'b0;
          err_count   <= '0;
          err_chan    <= '0;
          cycle_count <= '0;
          launch_cnt  <= '0;
        end
        RUN: begin
          err_count  <= err_next;
          err_chan   <= err_chan | mism;
          launch_cnt <= launch_cnt + CW'(1);
          if (cycle_count != 16'hFFFF) cycle_count <= cycle_count + 16'd1;
          if (launch_cnt == CW'(NUM_CYCLES - 1)) state <= DRAIN;
        end
        DRAIN: begin
          err_count <= err_next;
          err_chan  <= err_chan | mism;
          if (last_chk) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == 16'd0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SELFTEST_FINISH_EN
  logic done_q;
  always @(posedge clk) begin
    if (done && !done_q) begin
      if (pass) $display("*-* All Finished *-*");
      else      $display("%%Error: selftest_engine %0d errors", err_count);
      $finish;
    end
    done_q <= done;
  end
`endif
endmodule

// File: tb/tb_selftest_engine.sv
// Directed bench for selftest_engine at default parameters (2 channels, 64 words, latency 2).
module tb_selftest_engine;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  inject_err = 2'b00;
  logic        busy, done, pass;
  logic [15:0] err_count, cycle_count;
  logic [1:0]  err_chan;
  int          checks = 0;
  int          failures = 0;
  int          n;

  selftest_engine #(
    .WIDTH(16), .CHANNELS(2), .NUM_CYCLES(64), .LATENCY(2), .SEED(16'hACE1), .POLY(16'hB400)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .inject_err(inject_err),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .err_chan(err_chan), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until busy drops; a bound of 300 edges catches a hung engine.
  task automatic wait_done(output int cnt);
    cnt = 0;
    while (busy && cnt < 300) begin
      step();
      cnt++;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_pass"}, 32'(pass), 32'd0);
    check({tag, "_errc"}, 32'(err_count), 32'd0);
    check({tag, "_errch"}, 32'(err_chan), 32'd0);
    check({tag, "_cyc"}, 32'(cycle_count), 32'd0);
  endtask

  initial begin
    // Reset held with start toggling
    #1;
    for (int i = 0; i < 3; i++) begin
      start = ~start;
      step();
    end
    start = 1'b0;
    check_zero("reset");
    reset = 1'b0;
    step();
    check_zero("idle");

    // Clean run
    pulse_start();
    check("clean_busy_e0", 32'(busy), 32'd1);
    step();
    check("clean_cyc_e1", 32'(cycle_count), 32'd1);
    wait_done(n);
    check("clean_busy_len", 32'(n + 1), 32'd66);
    check("clean_done", 32'(done), 32'd1);
    check("clean_pass", 32'(pass), 32'd1);
    check("clean_errc", 32'(err_count), 32'd0);
    check("clean_errch", 32'(err_chan), 32'd0);
    check("clean_cyc", 32'(cycle_count), 32'd64);
    step();
    check("done_hold", 32'(done), 32'd1);

    // Single error on channel 0 at the 10th launch
    pulse_start();
    check("inj1_done_clr", 32'(done), 32'd0);
    for (int i = 0; i < 9; i++) step();
    check("inj1_cyc9", 32'(cycle_count), 32'd9);
    inject_err = 2'b01;
    step();
    inject_err = 2'b00;
    check("inj1_e10", 32'(err_count), 32'd0);
    step();
    check("inj1_e11", 32'(err_count), 32'd0);
    step();
    check("inj1_e12", 32'(err_count), 32'd1);
    wait_done(n);
    check("inj1_busy_len", 32'(n + 12), 32'd66);
    check("inj1_done", 32'(done), 32'd1);
    check("inj1_errc", 32'(err_count), 32'd1);
    check("inj1_errch", 32'(err_chan), 32'd1);
    check("inj1_pass", 32'(pass), 32'd0);

    // Both channels corrupted for the whole run; restart from DONE clears counters
    inject_err = 2'b11;
    pulse_start();
    check("inj3_errc_clr", 32'(err_count), 32'd0);
    check("inj3_errch_clr", 32'(err_chan), 32'd0);
    check("inj3_cyc_clr", 32'(cycle_count), 32'd0);
    wait_done(n);
    inject_err = 2'b00;
    check("inj3_busy_len", 32'(n), 32'd66);
    check("inj3_errc", 32'(err_count), 32'd128);
    check("inj3_errch", 32'(err_chan), 32'd3);
    check("inj3_pass", 32'(pass), 32'd0);

    // Asynchronous reset after launch 30
    pulse_start();
    for (int i = 0; i < 30; i++) step();
    check("abort_cyc30", 32'(cycle_count), 32'd30);
    #2 reset = 1'b1;
    #1;
    check_zero("abort");
    step();
    step();
    reset = 1'b0;
    step();
    check_zero("abort_idle");
    pulse_start();
    wait_done(n);
    check("rerun_busy_len", 32'(n), 32'd66);
    check("rerun_pass", 32'(pass), 32'd1);
    check("rerun_cyc", 32'(cycle_count), 32'd64);
    check("rerun_errc", 32'(err_count), 32'd0);

    // start during RUN is ignored
    pulse_start();
    for (int i = 0; i < 20; i++) step();
    pulse_start();
    check("ign_busy", 32'(busy), 32'd1);
    check("ign_cyc21", 32'(cycle_count), 32'd21);
    wait_done(n);
    check("ign_busy_len", 32'(n + 21), 32'd66);
    check("ign_done", 32'(done), 32'd1);
    check("ign_pass", 32'(pass), 32'd1);
    check("ign_cyc", 32'(cycle_count), 32'd64);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/selftest_engine.md
# selftest_engine

Parametrised built-in self-test engine for single-clock simulation and FPGA bring-up. One start pulse runs a fixed-length, multi-channel pseudo-random pattern through a configurable-latency delay line and checks every word against an independently regenerated expected stream. It reports done, pass and error statistics, and can optionally end simulation itself. It is the generalised successor of the team's fixed self-checking test designs, adding width, channel count, run length, pipeline depth and error injection.

## Interface
- WIDTH, 16: data word width per channel; must be ≥ 4.
- CHANNELS, 2: number of independent pattern channels; must be ≥ 1.
- NUM_CYCLES, 64: number of words launched per channel per run; must be ≥ 1.
- LATENCY, 2: depth of the delay line between generator and checker; must be ≥ 1.
- SEED, 16'hACE1: LFSR seed, truncated or zero-extended to WIDTH; must be nonzero.
- POLY, 16'hB400: Galois LFSR feedback mask, truncated to WIDTH.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle run request; honoured only in IDLE or DONE.
- inject_err  in  CHANNELS  per-channel error injection, sampled at launch.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE.
- pass  out  1  high in DONE when err_count == 0.
- err_count  out  16  saturating total of mismatching words.
- err_chan  out  CHANNELS  sticky per-channel mismatch flags.
- cycle_count  out  16  words launched in the current or last run.

## Operation
- States: IDLE → RUN → DRAIN → DONE; DONE → RUN on start.
- IDLE/DONE + start: go to RUN. Clear err_count, err_chan, cycle_count and all delay-line valids. Load generator and checker LFSR of channel c with SEED ^ c.
- RUN, each cycle:
  - Each channel launches its generator word into delay stage 1 with valid = 1. Bit 0 is inverted if inject_err[c] = 1.
  - The generator advances: lsb ? (x >> 1) ^ POLY : x >> 1.
  - cycle_count increments.
  - After NUM_CYCLES launches, go to DRAIN.
- Delay line: LATENCY register stages per channel, carrying data and a valid bit. Stages shift every cycle.
- Checker: when the last stage is valid, compare it against the checker LFSR, then advance the checker LFSR.
  - Mismatch on channel c sets err_chan[c].
  - err_count += popcount(mismatches this cycle), saturating at 16'hFFFF.
- DRAIN: no launches. Go to DONE on the cycle the final valid word is checked.
- DONE: outputs hold until start or reset.
- start in RUN or DRAIN is ignored.

## Timing
- Reset (asynchronous, immediate): state IDLE. busy, done, pass, err_count, err_chan and cycle_count all read 0. Delay valids are cleared.
- Reset mid-run aborts the run with no report and no finish message. The first start after reset runs cleanly.
- Start is sampled at edge E0. busy = 1 after E0.
- Words launch at edges E1 through E_NUM_CYCLES.
- The word launched at Ek is checked at edge Ek+LATENCY.
- After edge E(NUM_CYCLES+LATENCY): busy = 0, done = 1, pass valid. Total busy time is NUM_CYCLES+LATENCY cycles.
- Simultaneous mismatches on several channels in one cycle each count 1. Saturation holds at all-ones.
- cycle_count saturates at 16'hFFFF and wraps never.

## Configuration
- SELFTEST_FINISH_EN defined:
  - On entry to DONE, $display "*-* All Finished *-*" when pass = 1.
  - Otherwise $display "%%Error: selftest_engine N errors", with N being err_count.
  - Then $finish.
- Undefined: no display and no $finish. Completion is visible only through done, pass and the counters. This is the synthesisable form.

## Test plan
- Hold reset 3 cycles, with start toggling → all outputs 0, no state change. Release → IDLE, done = 0.
- Defaults, start pulse, inject_err = 0 → busy for exactly 66 cycles, then done = 1, pass = 1, err_count = 0, err_chan = 2'b00, cycle_count = 64.
- inject_err = 2'b01 for the 10th launch only → err_count = 1 at the edge 2 cycles later. Final err_chan = 2'b01, pass = 0.
- inject_err = 2'b11 held for the whole run → err_count = 128, err_chan = 2'b11, pass = 0.
- Assert reset asynchronously after launch 30 → outputs 0 before the next edge. A new start gives pass = 1 and cycle_count = 64.
- start pulse during RUN is ignored, with done still at edge E66. start in DONE restarts with counters cleared. With SELFTEST_FINISH_EN defined, a clean run prints "*-* All Finished *-*" and finishes.
